core_lsu: RTL and testbench

- Load/store stage directly downstream of the core ALU.
- Consumes the ALU's registered effective address (RS1+IMM) and the store data (RS2), together with the latched load/store decode flags.
- Runs one data-memory transaction per request over a REQ/ACK handshake.
- Returns byte/half/word-extracted, sign- or zero-extended load data to writeback, or reports misalignment/bus timeout.

---
 rtl/core_pkg.sv | 31 +++
 rtl/core_lsu_align.sv | 52 +++++
 rtl/core_lsu.sv | 178 +++++++++++++++++
 tb/tb_core_lsu.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core load/store stage: FSM states, access sizes
// and the datapath width.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_FIN  = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // True when an access of the given size cannot be issued at this byte offset.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering for the load/store stage: byte enables and replicated
// store data on the way out, lane extraction and extension on the way back.
module core_lsu_align
  import core_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte enables follow the offset; store data is replicated so every lane carries it.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (size)
      SZ_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane of the read word and sign- or zero-extend it.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    rdata_ext = {{(XLEN-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_H:    rdata_ext = {{(XLEN-16){~is_unsigned & half_lane[15]}}, half_lane};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store stage: one memory transaction per START over a REQ/ACK
// handshake, with misalignment detection and a bus timeout.
module core_lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            I_LB,
  input  logic            I_LH,
  input  logic            I_LW,
  input  logic            I_LBU,
  input  logic            I_LHU,
  input  logic            I_SB,
  input  logic            I_SH,
  input  logic            I_SW,
  input  logic [XLEN-1:0] ADDR,
  input  logic [XLEN-1:0] WDATA,
  output logic            MEM_REQ,
  output logic            MEM_WE,
  output logic [3:0]      MEM_BE,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic [XLEN-1:0] MEM_WDATA,
  input  logic [XLEN-1:0] MEM_RDATA,
  input  logic            MEM_ACK,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RD_DATA,
  output logic            ERR_MISALIGN,
  output logic            ERR_BUS
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state, state_nxt;
  lsu_size_e       op_size, size_q;
  logic            op_valid, op_we, op_uns, op_misalign;
  logic            we_q, uns_q;
  logic [XLEN-1:0] addr_q, wdata_q, rd_q;
  logic            err_mis_q, err_bus_q;
  logic [15:0]     tmo_cnt;
  logic            tmo_hit;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_lane, rdata_ext;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  core_lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (MEM_RDATA),
    .be          (be),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  // Decode the op flags with fixed priority LW > LH > LHU > LB > LBU > SW > SH > SB.
  always_comb begin
    op_valid = 1'b1;
    op_we    = 1'b0;
    op_uns   = 1'b0;
    op_size  = SZ_W;
    if (I_LW) begin
      op_size = SZ_W;
    end else if (I_LH) begin
      op_size = SZ_H;
    end else if (I_LHU) begin
      op_size = SZ_H;
      op_uns  = 1'b1;
    end else if (I_LB) begin
      op_size = SZ_B;
    end else if (I_LBU) begin
      op_size = SZ_B;
      op_uns  = 1'b1;
    end else if (I_SW) begin
      op_size = SZ_W;
      op_we   = 1'b1;
    end else if (I_SH) begin
      op_size = SZ_H;
      op_we   = 1'b1;
    end else if (I_SB) begin
      op_size = SZ_B;
      op_we   = 1'b1;
    end else begin
      op_valid = 1'b0;
    end
    op_misalign = op_valid & lsu_misaligned(op_size, ADDR[1:0]);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  // Next state: rejected or empty requests skip straight to the completion cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (START) state_nxt = (op_valid && !op_misalign) ? LSU_REQ : LSU_FIN;
      LSU_REQ:  if (MEM_ACK || tmo_hit) state_nxt = LSU_FIN;
      LSU_FIN:  state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  // Request latching, timeout counting and result registers (updated as FIN is entered).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      size_q    <= SZ_W;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_cnt   <= '0;
      rd_q      <= '0;
      err_mis_q <= 1'b0;
      err_bus_q <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (START) begin
            size_q  <= op_size;
            uns_q   <= op_uns;
            we_q    <= op_we;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            tmo_cnt <= '0;
            if (!op_valid || op_misalign) begin
              rd_q      <= '0;
              err_mis_q <= op_misalign;
              err_bus_q <= 1'b0;
            end
          end
        end
        LSU_REQ: begin
          if (MEM_ACK) begin
            rd_q      <= we_q ? '0 : rdata_ext;
            err_mis_q <= 1'b0;
            err_bus_q <= 1'b0;
          end else if (tmo_hit) begin
            rd_q      <= '0;
            err_mis_q <= 1'b0;
            err_bus_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the bus is driven only while a request is outstanding.
  always_comb begin
    MEM_REQ      = (state == LSU_REQ);
    MEM_WE       = 1'b0;
    MEM_BE       = 4'b0000;
    MEM_ADDR     = '0;
    MEM_WDATA    = '0;
    if (state == LSU_REQ) begin
      MEM_WE    = we_q;
      MEM_BE    = be;
      MEM_ADDR  = {addr_q[XLEN-1:2], 2'b00};
      MEM_WDATA = wdata_lane;
    end
    BUSY         = (state != LSU_IDLE);
    DONE         = (state == LSU_FIN);
    RD_DATA      = rd_q;
    ERR_MISALIGN = err_mis_q;
    ERR_BUS      = err_bus_q;
  end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: a transaction-level model predicts every
// cycle of each directed request, and a compare process checks it on negedges.
module tb_core_lsu;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW;
  logic [31:0] ADDR, WDATA, MEM_RDATA;
  logic        MEM_ACK;
  logic        MEM_REQ, MEM_WE, BUSY, DONE, ERR_MISALIGN, ERR_BUS;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_ADDR, MEM_WDATA, RD_DATA;

  core_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .I_LB         (I_LB),
    .I_LH         (I_LH),
    .I_LW         (I_LW),
    .I_LBU        (I_LBU),
    .I_LHU        (I_LHU),
    .I_SB         (I_SB),
    .I_SH         (I_SH),
    .I_SW         (I_SW),
    .ADDR         (ADDR),
    .WDATA        (WDATA),
    .MEM_REQ      (MEM_REQ),
    .MEM_WE       (MEM_WE),
    .MEM_BE       (MEM_BE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_ACK      (MEM_ACK),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .RD_DATA      (RD_DATA),
    .ERR_MISALIGN (ERR_MISALIGN),
    .ERR_BUS      (ERR_BUS)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int done_cycles = 0;

  logic        exp_req, exp_we, exp_busy, exp_done, exp_mis, exp_bus;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_rd;

  typedef struct {
    bit          noop;
    bit          mis;
    bit          store;
    bit          sgn;
    int          size;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Flag vector order: {LW, LH, LHU, LB, LBU, SW, SH, SB}.
  task automatic set_flags(input logic [7:0] f);
    {I_LW, I_LH, I_LHU, I_LB, I_LBU, I_SW, I_SH, I_SB} = f;
  endtask

  // What a request must produce, from sizes in bytes and plain arithmetic.
  function automatic txn_t model(input logic [7:0] f, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdv);
    txn_t   t;
    int     lane;
    longint mask, v;
    t = '{default: 0};
    lane = int'(a[1:0]);
    if      (f[7]) t.size = 4;
    else if (f[6]) begin t.size = 2; t.sgn = 1; end
    else if (f[5]) t.size = 2;
    else if (f[4]) begin t.size = 1; t.sgn = 1; end
    else if (f[3]) t.size = 1;
    else if (f[2]) begin t.size = 4; t.store = 1; end
    else if (f[1]) begin t.size = 2; t.store = 1; end
    else if (f[0]) begin t.size = 1; t.store = 1; end
    else t.noop = 1;
    if (t.noop) return t;
    t.mis = (lane % t.size) != 0;
    if (t.mis) return t;
    t.be = 4'(((1 << t.size) - 1) << lane);
    if (t.size == 1)      t.wd = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (t.size == 2) t.wd = {16'd0, wd[15:0]} * 32'h0001_0001;
    else                  t.wd = wd;
    mask = (64'd1 << (8 * t.size)) - 1;
    v = (longint'({32'd0, rdv}) >> (8 * lane)) & mask;
    if (t.sgn && v[8 * t.size - 1]) v = v | ~mask;
    t.rd = t.store ? 32'd0 : v[31:0];
    return t;
  endfunction

  // Issue one request; ack_after = REQ cycle index carrying ACK (-1 = never).
  // With poke set, START with LW is held high throughout the busy period.
  task automatic apply_stimulus(input logic [7:0] f, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdv, input int ack_after, input bit poke);
    txn_t t;
    int   k;
    bit   fin;
    t = model(f, a, wd, rdv);
    req_cycles  = 0;
    done_cycles = 0;
    START = 1'b1;
    set_flags(f);
    ADDR  = a;
    WDATA = wd;
    @(posedge CLK); #1;
    START = 1'b0;
    set_flags(8'h00);
    ADDR  = 32'hA5A5_5A5F;
    WDATA = 32'h5A5A_A5A5;
    exp_busy = 1'b1;
    if (!t.noop && !t.mis) begin
      exp_req   = 1'b1;
      exp_we    = t.store;
      exp_be    = t.be;
      exp_addr  = {a[31:2], 2'b00};
      exp_wdata = t.wd;
      exp_done  = 1'b0;
      k   = 0;
      fin = 1'b0;
      while (!fin) begin
        if (poke) begin START = 1'b1; set_flags(8'h80); end
        if (k == ack_after) begin MEM_ACK = 1'b1; MEM_RDATA = rdv; end
        @(posedge CLK); #1;
        MEM_ACK   = 1'b0;
        MEM_RDATA = 32'hCCCC_3333;
        if (k == ack_after || k == TMO - 1) fin = 1'b1;
        else k++;
      end
      exp_req = 1'b0;
      exp_we  = 1'b0;
      if (k == ack_after) begin
        exp_rd  = t.rd;
        exp_mis = 1'b0;
        exp_bus = 1'b0;
      end else begin
        exp_rd  = 32'd0;
        exp_mis = 1'b0;
        exp_bus = 1'b1;
      end
    end else begin
      exp_rd  = 32'd0;
      exp_mis = t.mis;
      exp_bus = 1'b0;
    end
    exp_done = 1'b1;
    if (poke) begin START = 1'b1; set_flags(8'h80); ADDR = 32'h0; end
    @(posedge CLK); #1;
    START = 1'b0;
    set_flags(8'h00);
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Start a load that never gets ACK and hit it with reset in its second REQ cycle.
  task automatic reset_mid_req();
    START = 1'b1;
    set_flags(8'h80);
    ADDR = 32'h300;
    @(posedge CLK); #1;
    START = 1'b0;
    set_flags(8'h00);
    exp_busy = 1'b1;
    exp_req  = 1'b1;
    exp_we   = 1'b0;
    exp_be   = 4'hF;
    exp_addr = 32'h300;
    @(posedge CLK); #3;
    RST = 1'b1;
    exp_busy = 1'b0;
    exp_req  = 1'b0;
    exp_done = 1'b0;
    exp_rd   = 32'd0;
    exp_mis  = 1'b0;
    exp_bus  = 1'b0;
    #1;
    check_output("rst_mem_req", 32'(MEM_REQ), 32'd0);
    check_output("rst_busy", 32'(BUSY), 32'd0);
    check_output("rst_done", 32'(DONE), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    MEM_ACK   = 1'b1;
    MEM_RDATA = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Cycle-by-cycle comparison against the model's expectations.
  always @(negedge CLK) begin
    check_output("MEM_REQ", 32'(MEM_REQ), 32'(exp_req));
    check_output("BUSY", 32'(BUSY), 32'(exp_busy));
    check_output("DONE", 32'(DONE), 32'(exp_done));
    check_output("RD_DATA", RD_DATA, exp_rd);
    check_output("ERR_MISALIGN", 32'(ERR_MISALIGN), 32'(exp_mis));
    check_output("ERR_BUS", 32'(ERR_BUS), 32'(exp_bus));
    if (exp_req) begin
      check_output("MEM_WE", 32'(MEM_WE), 32'(exp_we));
      check_output("MEM_BE", 32'(MEM_BE), 32'(exp_be));
      check_output("MEM_ADDR", MEM_ADDR, exp_addr);
      if (exp_we) check_output("MEM_WDATA", MEM_WDATA, exp_wdata);
    end
    if (MEM_REQ) req_cycles++;
    if (DONE)    done_cycles++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    START = 1'b0;
    set_flags(8'h00);
    ADDR = '0; WDATA = '0; MEM_RDATA = '0; MEM_ACK = 1'b0;
    exp_req = 0; exp_we = 0; exp_busy = 0; exp_done = 0; exp_mis = 0; exp_bus = 0;
    exp_be = '0; exp_addr = '0; exp_wdata = '0; exp_rd = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    apply_stimulus(8'h80, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    check_output("lw_rd", RD_DATA, 32'hDEAD_BEEF);
    check_output("lw_req_cycles", 32'(req_cycles), 32'd1);

    apply_stimulus(8'h10, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0);
    check_output("lb_rd", RD_DATA, 32'hFFFF_FF80);
    apply_stimulus(8'h08, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check_output("lbu_rd", RD_DATA, 32'h0000_0080);

    apply_stimulus(8'h02, 32'h202, 32'h0000_ABCD, 32'h0, 3, 1'b1);
    check_output("sh_req_cycles", 32'(req_cycles), 32'd4);
    check_output("sh_done_cycles", 32'(done_cycles), 32'd1);
    check_output("sh_rd", RD_DATA, 32'd0);

    apply_stimulus(8'h80, 32'h101, 32'h0, 32'h0, 0, 1'b1);
    check_output("mis_flag", 32'(ERR_MISALIGN), 32'd1);
    check_output("mis_req_cycles", 32'(req_cycles), 32'd0);
    check_output("mis_done_cycles", 32'(done_cycles), 32'd1);

    apply_stimulus(8'h04, 32'h400, 32'h1234_5678, 32'h0, -1, 1'b0);
    check_output("tmo_bus", 32'(ERR_BUS), 32'd1);
    check_output("tmo_rd", RD_DATA, 32'd0);
    check_output("tmo_req_cycles", 32'(req_cycles), 32'd4);

    apply_stimulus(8'h80, 32'h600, 32'h0, 32'h0F0E_0D0C, TMO - 1, 1'b0);
    check_output("ack_at_tmo_bus", 32'(ERR_BUS), 32'd0);
    check_output("ack_at_tmo_rd", RD_DATA, 32'h0F0E_0D0C);

    apply_stimulus(8'h14, 32'h102, 32'h0, 32'h007F_0000, 0, 1'b0);
    check_output("prio_lb_rd", RD_DATA, 32'h0000_007F);
    apply_stimulus(8'h61, 32'h102, 32'h0, 32'h8001_0000, 2, 1'b0);
    check_output("prio_lh_rd", RD_DATA, 32'hFFFF_8001);
    apply_stimulus(8'h20, 32'h106, 32'h0, 32'h9ABC_5678, 0, 1'b0);
    check_output("lhu_rd", RD_DATA, 32'h0000_9ABC);
    apply_stimulus(8'h01, 32'h001, 32'h0000_00EE, 32'h0, 1, 1'b0);
    apply_stimulus(8'h04, 32'h002, 32'h1111_2222, 32'h0, 0, 1'b0);
    apply_stimulus(8'h40, 32'h103, 32'h0, 32'h0, 0, 1'b0);
    apply_stimulus(8'h00, 32'h104, 32'h0, 32'h0, 0, 1'b0);
    check_output("noop_rd", RD_DATA, 32'd0);
    check_output("noop_done_cycles", 32'(done_cycles), 32'd1);

    reset_mid_req();
    apply_stimulus(8'h80, 32'h500, 32'h0, 32'h1122_3344, 2, 1'b0);
    check_output("post_rst_rd", RD_DATA, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
